// File: rtl/piso_serializer_msb_if.sv
// Word-load handshake and serial output bundle for the MSB-first serializer.
// master = word producer / bit consumer side, slave = the serializer.
interface piso_serializer_msb_if #(
  parameter int WIDTH = 11,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             data_out;
  logic             bit_valid;
  logic             word_done;
  logic [CNT_W-1:0] bits_left;

  modport master (
    output load_data, load_valid, shift_en,
    input  load_ready, data_out, bit_valid, word_done, bits_left
  );

  modport slave (
    input  load_data, load_valid, shift_en,
    output load_ready, data_out, bit_valid, word_done, bits_left
  );
endinterface

// File: rtl/piso_serializer_msb.sv
// Parallel-in/serial-out, MSB first; first bit one cycle after accept, back-to-back with no bubble.
// shift_en low freezes every output; no word is accepted while a word is frozen mid-stream.
module piso_serializer_msb #(
  parameter int   WIDTH    = 11,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_serializer_msb_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_data_out;
  logic             r_bit_valid;
  logic             r_word_done;
  logic [CNT_W-1:0] r_bits_left;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_data_nxt;
  logic             w_valid_nxt;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_left_nxt;
  logic             w_load_ready;
  logic             w_accept;

  // Ready in the last-bit cycle lets the next word follow with no idle gap.
  assign w_load_ready = (r_state == IDLE) ||
                        ((r_state == SHIFT) && (r_bits_left == '0) && bus.shift_en);
  assign w_accept     = bus.load_valid && w_load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_data_out  <= IDLE_BIT;
      r_bit_valid <= 1'b0;
      r_word_done <= 1'b0;
      r_bits_left <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_data_out  <= w_data_nxt;
      r_bit_valid <= w_valid_nxt;
      r_word_done <= w_done_nxt;
      r_bits_left <= w_left_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data_out;
    w_valid_nxt = r_bit_valid;
    w_done_nxt  = r_word_done;
    w_left_nxt  = r_bits_left;

    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_data_nxt  = bus.load_data[WIDTH-1];
      w_shreg_nxt = {bus.load_data[WIDTH-2:0], 1'b0};
      w_left_nxt  = CNT_W'(WIDTH - 1);
      w_valid_nxt = 1'b1;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        SHIFT: begin
          if (bus.shift_en) begin
            if (r_bits_left != '0) begin
              w_data_nxt  = r_shreg[WIDTH-1];
              w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
              w_left_nxt  = r_bits_left - 1'b1;
              w_done_nxt  = (r_bits_left == CNT_W'(1));
            end else begin
              w_state_nxt = IDLE;
              w_valid_nxt = 1'b0;
              w_data_nxt  = IDLE_BIT;
              w_done_nxt  = 1'b0;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.data_out   = r_data_out;
  assign bus.bit_valid  = r_bit_valid;
  assign bus.word_done  = r_word_done;
  assign bus.bits_left  = r_bits_left;

endmodule

// File: tb/tb_piso_serializer_msb.sv
// Bench for piso_serializer_msb: per-bit scoreboard fed on accept, table of words/stalls, directed corner cases.
module tb_piso_serializer_msb;
  localparam int   W        = 11;
  localparam int   CW       = 4;
  localparam logic IDLE_BIT = 1'b0;

  logic clk = 1'b0;
  logic rst;

  piso_serializer_msb_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  piso_serializer_msb #(.WIDTH(W), .CNT_W(CW), .IDLE_BIT(IDLE_BIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          b;
    logic [CW-1:0] left;
    logic          done;
  } exp_t;

  typedef struct {
    logic [W-1:0] data;
    int           stall_left;
    int           stall_len;
    int           exp_span;
  } vec_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] last_pushed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b    = w[W-1-i];
      e.left = CW'(W - 1 - i);
      e.done = (i == W - 1);
      sb.push_back(e);
    end
    last_pushed = w;
  endtask

  // A bit counts as delivered in a valid cycle whose closing edge has shift_en high.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (bus.bit_valid && bus.shift_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_bit", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_data", bus.data_out, e.b);
        chk("sb_left", bus.bits_left, e.left);
        chk("sb_done", bus.word_done, e.done);
      end
    end else if (!bus.bit_valid) begin
      chk("idle_out", {bus.data_out, bus.word_done}, {IDLE_BIT, 1'b0});
    end
    if (bus.load_valid && bus.load_ready && !rst) push_word(bus.load_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    while (bus.bit_valid && guard < 40) begin
      cycle();
      guard++;
    end
    chk({nm, "_ended"}, bus.bit_valid, 1'b0);
    chk({nm, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t         vecs[5];
    logic [W-1:0] vals[W];
    int           span, guard;
    bit           stalled;

    vecs[0] = '{11'b10011010101, -1, 0, 11};
    vecs[1] = '{11'h4D5,          5, 3, 14};
    vecs[2] = '{11'h7FF,          0, 2, 13};
    vecs[3] = '{11'h001,         10, 1, 12};
    vecs[4] = '{11'h2AA,         -1, 0, 11};

    bus.load_data  = '0;
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b1;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_data_out", bus.data_out, IDLE_BIT);
    chk("rst_bit_valid", bus.bit_valid, 1'b0);
    chk("rst_word_done", bus.word_done, 1'b0);
    chk("rst_bits_left", bus.bits_left, 0);
    chk("rst_load_ready", bus.load_ready, 1'b1);
    rst = 1'b0;
    cycle();

    // Table: word, bits_left value to stall at (-1 none), stall length, expected valid span.
    for (int v = 0; v < 5; v++) begin
      bus.shift_en   = 1'b1;
      bus.load_data  = vecs[v].data;
      bus.load_valid = 1'b1;
      cycle();
      bus.load_valid = 1'b0;
      bus.load_data  = W'($urandom);
      span = 0; guard = 0; stalled = 1'b0;
      while (bus.bit_valid && guard < 40) begin
        span++;
        guard++;
        if (!stalled && vecs[v].stall_len > 0 && int'(bus.bits_left) == vecs[v].stall_left) begin
          stalled = 1'b1;
          bus.shift_en = 1'b0;
          for (int k = 0; k < vecs[v].stall_len; k++) begin
            cycle();
            span++;
            chk("stall_left_hold", bus.bits_left, vecs[v].stall_left);
            chk("stall_valid_hold", bus.bit_valid, 1'b1);
            chk("stall_done_hold", bus.word_done, vecs[v].stall_left == 0);
            chk("stall_ready", bus.load_ready, 1'b0);
          end
          bus.shift_en = 1'b1;
        end
        cycle();
      end
      chk("word_span", span, vecs[v].exp_span);
      chk("word_drained", sb.size(), 0);
    end

    // Back-to-back: second word follows the last bit of the first with no gap.
    bus.shift_en   = 1'b1;
    bus.load_data  = 11'h4D5;
    bus.load_valid = 1'b1;
    cycle();
    bus.load_data  = 11'h2AA;
    for (int i = 0; i < 2 * W; i++) begin
      if (i < W) chk("b2b_ready", bus.load_ready, i == W - 1);
      chk("b2b_contig", bus.bit_valid, 1'b1);
      cycle();
      if (i == W - 1) bus.load_valid = 1'b0;
    end
    chk("b2b_end", bus.bit_valid, 1'b0);
    chk("b2b_drained", sb.size(), 0);

    // Producer keeps changing the held word; only the accept-edge value goes out.
    bus.load_data  = 11'h5A5;
    bus.load_valid = 1'b1;
    cycle();
    for (int i = 0; i < W; i++) begin
      vals[i]       = W'((i * 389 + 77) % 2048);
      bus.load_data = vals[i];
      chk("hold_ready", bus.load_ready, i == W - 1);
      cycle();
    end
    bus.load_valid = 1'b0;
    chk("hold_accepted", last_pushed, vals[W-1]);
    drain("hold");

    // Asynchronous reset mid-word, then a fresh word from its MSB.
    bus.load_data  = 11'h6B3;
    bus.load_valid = 1'b1;
    cycle();
    bus.load_valid = 1'b0;
    guard = 0;
    while (bus.bits_left != 4 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("mid_reached_left4", bus.bits_left, 4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data_out", bus.data_out, IDLE_BIT);
    chk("mid_rst_bit_valid", bus.bit_valid, 1'b0);
    chk("mid_rst_bits_left", bus.bits_left, 0);
    chk("mid_rst_word_done", bus.word_done, 1'b0);
    sb.delete();
    cycle();
    rst = 1'b0;
    chk("mid_rst_ready", bus.load_ready, 1'b1);
    bus.load_data  = 11'h3C9;
    bus.load_valid = 1'b1;
    cycle();
    bus.load_valid = 1'b0;
    chk("mid_new_msb", bus.data_out, 1'b0);
    chk("mid_new_left", bus.bits_left, W - 1);
    drain("mid_new");

    // Accept in IDLE with shift_en low: MSB appears, then holds until shift_en rises.
    bus.shift_en   = 1'b0;
    bus.load_data  = 11'h6C1;
    bus.load_valid = 1'b1;
    chk("idle_en0_ready", bus.load_ready, 1'b1);
    cycle();
    bus.load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("idle_en0_msb", bus.data_out, 1'b1);
      chk("idle_en0_valid", bus.bit_valid, 1'b1);
      chk("idle_en0_left", bus.bits_left, W - 1);
      cycle();
    end
    bus.shift_en = 1'b1;
    drain("idle_en0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
